// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [2:0] {
    MODE_OFF      = 3'd0,
    MODE_SWEEP_L  = 3'd1,
    MODE_SWEEP_R  = 3'd2,
    MODE_FILL     = 3'd3,
    MODE_DRAIN    = 3'd4,
    MODE_PINGPONG = 3'd5,
    MODE_BLINK    = 3'd6,
    MODE_RSVD     = 3'd7
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Number of frames in one pass of a pattern.
  function automatic int unsigned seq_len(input mode_e m, input int unsigned n);
    case (m)
      MODE_SWEEP_L, MODE_SWEEP_R, MODE_FILL, MODE_DRAIN: return n;
      MODE_PINGPONG: return 2 * n - 2;
      MODE_BLINK:    return 2;
      default:       return 1;
    endcase
  endfunction

  function automatic logic mode_valid(input mode_e m);
    return (m != MODE_OFF) && (m != MODE_RSVD);
  endfunction

endpackage

// File: rtl/led_step_tick.sv
// Frame-hold prescaler: one-cycle tick every STEP_CYCLES cycles, held at zero while clr is high.
module led_step_tick #(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW = $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_c = !clr && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_seq.sv
// Parametrised LED pattern sequencer: one engine for sweep, fill, drain, ping-pong and blink
// patterns, with one-shot/loop operation and start/stop/done handshakes.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_FRE        = 50000000,
  parameter int unsigned STEP_MS        = 200,
  parameter int unsigned N_LED          = 6,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic [N_LED-1:0] LED,
  output logic             busy,
  output logic             done
);

  localparam int unsigned STEP_CYCLES = CLK_FRE / 1000 * STEP_MS;
  localparam int unsigned KW          = $clog2(2 * N_LED);
  localparam logic [N_LED-1:0] POL     = {N_LED{LED_ACTIVE_LOW}};
  localparam logic [N_LED-1:0] TOP     = N_LED'(N_LED - 1);
  localparam logic [N_LED-1:0] NUM     = N_LED'(N_LED);
  localparam logic [N_LED-1:0] PP_BASE = N_LED'(2 * N_LED - 2);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N_LED-1:0] led_d;
  logic            busy_d, done_d;
  logic            tick_c, last_c, clr_c;
  mode_e           mode_in_c;

  // Active-high frame for pattern m at index k.
  function automatic logic [N_LED-1:0] frame_of(input mode_e m, input logic [KW-1:0] k);
    logic [N_LED-1:0] f, kn, p, idx;
    f  = '0;
    kn = N_LED'(k);
    p  = (kn < NUM) ? kn : (PP_BASE - kn);
    for (int unsigned i = 0; i < N_LED; i++) begin
      idx = N_LED'(i);
      case (m)
        MODE_SWEEP_L:  f[i] = (idx == kn);
        MODE_SWEEP_R:  f[i] = (idx == (TOP - kn));
        MODE_FILL:     f[i] = (idx <= kn);
        MODE_DRAIN:    f[i] = (idx <= (TOP - kn));
        MODE_PINGPONG: f[i] = (idx == p);
        MODE_BLINK:    f[i] = (kn == '0);
        default:       f[i] = 1'b0;
      endcase
    end
    return f;
  endfunction

  assign clr_c     = (state_q == S_IDLE);
  assign mode_in_c = mode_e'(mode);
  assign last_c    = (k_q == KW'(seq_len(mode_q, N_LED) - 1));

  led_step_tick #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_c),
    .tick_c(tick_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_OFF;
      k_q     <= '0;
      LED     <= POL;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      LED     <= led_d ^ POL;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state and next registered outputs; stop outranks a simultaneous wrap.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    k_d     = k_q;
    led_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && mode_valid(mode_in_c)) begin
          state_d = S_RUN;
          mode_d  = mode_in_c;
          k_d     = '0;
          busy_d  = 1'b1;
          led_d   = frame_of(mode_in_c, '0);
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        led_d  = frame_of(mode_q, k_q);
        if (stop) begin
          state_d = S_IDLE;
          k_d     = '0;
          busy_d  = 1'b0;
          led_d   = '0;
        end else if (tick_c) begin
          if (!last_c) begin
            k_d   = k_q + KW'(1);
            led_d = frame_of(mode_q, k_q + KW'(1));
          end else if (loop) begin
            k_d   = '0;
            led_d = frame_of(mode_q, '0);
          end else begin
            state_d = S_IDLE;
            k_d     = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            led_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares both an active-high and an active-low instance.
module tb_led_pattern_seq;

  typedef struct packed {
    logic [5:0] led;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, loop, start, stop;
  logic [2:0] mode;
  logic [5:0] led_h, led_l;
  logic       busy_h, done_h, busy_l, done_l;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  logic [5:0] swl [6]  = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
  logic [5:0] fill[6]  = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F};
  logic [5:0] pp  [10] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10, 6'h08, 6'h04, 6'h02};

  always #5 clk = ~clk;

  led_pattern_seq #(.CLK_FRE(1000), .STEP_MS(4), .N_LED(6), .LED_ACTIVE_LOW(1'b0)) u_dut_h (
    .clk(clk), .rst(rst), .mode(mode), .loop(loop), .start(start), .stop(stop),
    .LED(led_h), .busy(busy_h), .done(done_h)
  );

  led_pattern_seq #(.CLK_FRE(1000), .STEP_MS(4), .N_LED(6), .LED_ACTIVE_LOW(1'b1)) u_dut_l (
    .clk(clk), .rst(rst), .mode(mode), .loop(loop), .start(start), .stop(stop),
    .LED(led_l), .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", name, cyc_n, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      cyc_n++;
      chk("led_hi", led_h, e.led);
      chk("busy_hi", {5'b0, busy_h}, {5'b0, e.busy});
      chk("done_hi", {5'b0, done_h}, {5'b0, e.done});
      chk("led_lo", led_l, ~e.led);
      chk("busy_lo", {5'b0, busy_l}, {5'b0, e.busy});
      chk("done_lo", {5'b0, done_l}, {5'b0, e.done});
    end
  end

  // Advance one clock, then queue what the outputs must show in the cycle just begun.
  task automatic cyc(input logic [5:0] led, input logic b, input logic d);
    @(posedge clk);
    #1;
    q.push_back({led, b, d});
  endtask

  task automatic hold(input logic [5:0] led, input logic b, input logic d, input int n);
    for (int i = 0; i < n; i++) cyc(led, b, d);
  endtask

  // Drop reset between edges; outputs must clear before the next edge.
  task automatic async_rst();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    q.push_back({6'h00, 1'b0, 1'b0});
  endtask

  initial begin
    rst = 1'b0; loop = 1'b0; start = 1'b0; stop = 1'b0; mode = 3'd0;
    hold(6'h00, 1'b0, 1'b0, 2);
    rst = 1'b1;
    hold(6'h00, 1'b0, 1'b0, 2);

    // One-shot left sweep.
    mode = 3'd1; start = 1'b1;
    cyc(swl[0], 1'b1, 1'b0);
    start = 1'b0;
    hold(swl[0], 1'b1, 1'b0, 3);
    for (int f = 1; f < 6; f++) hold(swl[f], 1'b1, 1'b0, 4);
    cyc(6'h00, 1'b0, 1'b1);
    cyc(6'h00, 1'b0, 1'b0);

    // Looping ping-pong, loop dropped mid fourth pass.
    mode = 3'd5; loop = 1'b1; start = 1'b1;
    cyc(pp[0], 1'b1, 1'b0);
    start = 1'b0;
    hold(pp[0], 1'b1, 1'b0, 3);
    for (int f = 1; f < 10; f++) hold(pp[f], 1'b1, 1'b0, 4);
    for (int p = 0; p < 2; p++)
      for (int f = 0; f < 10; f++) hold(pp[f], 1'b1, 1'b0, 4);
    for (int f = 0; f < 5; f++) hold(pp[f], 1'b1, 1'b0, 4);
    loop = 1'b0;
    for (int f = 5; f < 10; f++) hold(pp[f], 1'b1, 1'b0, 4);
    cyc(6'h00, 1'b0, 1'b1);
    cyc(6'h00, 1'b0, 1'b0);

    // Fill aborted at frame 2, with a start in the stop cycle.
    mode = 3'd3; start = 1'b1;
    cyc(fill[0], 1'b1, 1'b0);
    start = 1'b0;
    hold(fill[0], 1'b1, 1'b0, 3);
    hold(fill[1], 1'b1, 1'b0, 4);
    hold(fill[2], 1'b1, 1'b0, 2);
    stop = 1'b1; start = 1'b1;
    cyc(6'h00, 1'b0, 1'b0);
    stop = 1'b0; start = 1'b0;
    hold(6'h00, 1'b0, 1'b0, 2);
    stop = 1'b1; start = 1'b1;
    cyc(6'h00, 1'b0, 1'b0);
    stop = 1'b0; start = 1'b0;
    hold(6'h00, 1'b0, 1'b0, 2);

    // Blink with a mode change and a restart attempt while busy.
    mode = 3'd6; start = 1'b1;
    cyc(6'h3F, 1'b1, 1'b0);
    start = 1'b0; mode = 3'd2;
    cyc(6'h3F, 1'b1, 1'b0);
    start = 1'b1;
    cyc(6'h3F, 1'b1, 1'b0);
    start = 1'b0;
    cyc(6'h3F, 1'b1, 1'b0);
    hold(6'h00, 1'b1, 1'b0, 4);
    cyc(6'h00, 1'b0, 1'b1);

    // Start accepted in the done cycle, then reset mid frame 3.
    mode = 3'd1; start = 1'b1;
    cyc(swl[0], 1'b1, 1'b0);
    start = 1'b0;
    hold(swl[0], 1'b1, 1'b0, 3);
    hold(swl[1], 1'b1, 1'b0, 4);
    hold(swl[2], 1'b1, 1'b0, 4);
    hold(swl[3], 1'b1, 1'b0, 2);
    async_rst();
    cyc(6'h00, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(6'h00, 1'b0, 1'b0);

    // Invalid modes never start.
    mode = 3'd0; start = 1'b1;
    cyc(6'h00, 1'b0, 1'b0);
    start = 1'b0;
    cyc(6'h00, 1'b0, 1'b0);
    mode = 3'd7; start = 1'b1;
    cyc(6'h00, 1'b0, 1'b0);
    start = 1'b0;
    hold(6'h00, 1'b0, 1'b0, 3);

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
